// File: rtl/cg_write_arbiter.sv
// Round-robin write arbiter for a shared enabled register,
// plus clock-gate control that sleeps the register clock when idle.
module cg_write_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] REQ_DATA,
  output logic [N_REQ-1:0]       GNT,
  output logic [WIDTH-1:0]       D_IN,
  output logic                   EN,
  output logic                   CG_EN,
  output logic [15:0]            WAKE_CNT
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {
    SLEEP  = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, rr_nxt;
  logic [CW-1:0]    idle_cnt, idle_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [WIDTH-1:0] d_in_nxt;
  logic             en_nxt;
  logic             cg_nxt;
  logic [15:0]      wake_nxt;

  logic [PW-1:0]    g;
  logic [PW-1:0]    g_try;
  logic             found;

  // Search starts one past the last winner so service rotates.
  always_comb begin
    found = 1'b0;
    g     = rr_ptr;
    g_try = rr_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      g_try = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && REQ[g_try]) begin
        found = 1'b1;
        g     = g_try;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    idle_nxt  = idle_cnt;
    gnt_nxt   = '0;
    d_in_nxt  = D_IN;
    en_nxt    = 1'b0;
    cg_nxt    = CG_EN;
    wake_nxt  = WAKE_CNT;
    unique case (state)
      SLEEP: begin
        cg_nxt = 1'b0;
        if (|REQ) begin
          state_nxt = WAKE;
          cg_nxt    = 1'b1;
          wake_nxt  = WAKE_CNT + 16'd1;
        end
      end
      WAKE: begin
        cg_nxt    = 1'b1;
        state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (found) begin
          gnt_nxt  = {{(N_REQ-1){1'b0}}, 1'b1} << g;
          d_in_nxt = REQ_DATA[g*WIDTH +: WIDTH];
          en_nxt   = 1'b1;
          rr_nxt   = g;
          idle_nxt = '0;
        end else if (idle_cnt == CW'(IDLE_CYCLES - 1)) begin
          state_nxt = SLEEP;
          cg_nxt    = 1'b0;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = SLEEP;
        cg_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= SLEEP;
      rr_ptr   <= PW'(N_REQ - 1);
      idle_cnt <= '0;
      GNT      <= '0;
      D_IN     <= '0;
      EN       <= 1'b0;
      CG_EN    <= 1'b0;
      WAKE_CNT <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      idle_cnt <= idle_nxt;
      GNT      <= gnt_nxt;
      D_IN     <= d_in_nxt;
      EN       <= en_nxt;
      CG_EN    <= cg_nxt;
      WAKE_CNT <= wake_nxt;
    end
  end

endmodule
